// File: rtl/wino_tile_controller.sv
// Winograd F(2x2,3x3) tile sequencer: latches the filter, admits input tiles under
// credit control, tracks them through the fixed-latency datapath and buffers the
// results in a first-word-fall-through output FIFO.
`timescale 1ns/1ps

module wino_tile_controller #(
  parameter int PIPE_LAT   = 3,
  parameter int FILT_LAT   = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_tiles,
  input  logic [71:0]      cfg_filter,
  output logic             busy,
  output logic             done,
  input  logic             s_data_valid,
  output logic             s_data_ready,
  input  logic [127:0]     s_data,
  output logic [71:0]      dp_filter,
  output logic [127:0]     dp_data,
  input  logic [127:0]     dp_y,
  output logic             m_y_valid,
  input  logic             m_y_ready,
  output logic [127:0]     m_y
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] FL_LAST  = FW'(FILT_LAT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FLOAD, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  num, issued, issued_nxt;
  logic [CW-1:0]     inflight, fifo_cnt;
  logic [CW:0]       credit_used;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     fl_cnt;
  logic [PIPE_LAT:0] vpipe;
  logic [127:0]      mem [FIFO_DEPTH];
  logic              accept, push, pop, start_job, done_nxt;

  // Handshake, credit and FIFO status decode from registered state only.
  assign credit_used  = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign s_data_ready = (state == RUN) && (issued < num) && (credit_used < DEPTH_C);
  assign accept       = s_data_valid && s_data_ready;
  assign issued_nxt   = issued + CNT_W'(accept);
  assign push         = vpipe[PIPE_LAT];
  assign m_y_valid    = (fifo_cnt != '0);
  assign pop          = m_y_valid && m_y_ready;
  assign busy         = (state != IDLE);
  // Head is forced to zero when empty so the unreset storage never shows on the port.
  assign m_y          = m_y_valid ? mem[rd_ptr] : '0;

  // Job state register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and job-start / completion strobes.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start_job = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_num_tiles != '0) begin
            start_job = 1'b1;
            state_nxt = FLOAD;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FLOAD: begin
        if (fl_cnt == FL_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (issued_nxt == num) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job configuration, filter-settle timer, issued count and datapath operand registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num       <= '0;
      issued    <= '0;
      fl_cnt    <= '0;
      done      <= 1'b0;
      dp_filter <= '0;
      dp_data   <= '0;
    end else begin
      done <= done_nxt;
      if (start_job) begin
        num       <= cfg_num_tiles;
        issued    <= '0;
        dp_filter <= cfg_filter;
      end else if (accept) begin
        issued <= issued_nxt;
      end
      if (accept) dp_data <= s_data;
      if (state == FLOAD) fl_cnt <= fl_cnt + FW'(1);
      else                fl_cnt <= '0;
    end
  end

  // Valid pipe mirrors the datapath latency; inflight counts set bits not yet written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      vpipe <= {vpipe[PIPE_LAT-1:0], accept};
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Output FIFO occupancy and wrapping pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Result storage.
  // NOTE: the storage array is deliberately not reset; occupancy is reset and the head is gated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dp_y;
  end

endmodule

// File: tb/tb_wino_tile_controller.sv
// Scoreboard bench for wino_tile_controller: a behavioural datapath model closes the
// dp_* loop, accepts push expected results, and a negedge monitor checks every output.
`timescale 1ns/1ps

module tb_wino_tile_controller;

  localparam logic [71:0]  F1 = 72'h090807060504030201;
  localparam logic [71:0]  F2 = 72'h010203010203010203;
  localparam logic [71:0]  F3 = 72'h020001000300010002;
  localparam logic [127:0] D1 = 128'h04040404030303030202020201010101;
  // Hand-computed correlation of F1 over D1: y00=y01=108, y10=y11=153.
  localparam logic [127:0] Y1 = 128'h00000099_00000099_0000006C_0000006C;
  localparam int LIMIT = 2000;

  logic         clk, rstn, cfg_start;
  logic [15:0]  cfg_num_tiles;
  logic [71:0]  cfg_filter, dp_filter;
  logic         busy, done, s_data_valid, s_data_ready, m_y_valid, m_y_ready;
  logic [127:0] s_data, dp_data, m_y;
  logic [127:0] dp_y = '0, m1 = '0, m2 = '0;

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [127:0] sb_q[$];
  int acc_cyc[$], pop_cyc[$], vrise_cyc[$], done_cyc[$];
  logic [71:0]  exp_filter = '0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [127:0] prev_y = '0, last_y = '0, exp_y;
  logic         abort = 1'b0, sender_busy = 1'b0;
  int a0, p0, v0, d0;

  wino_tile_controller dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_num_tiles(cfg_num_tiles),
    .cfg_filter(cfg_filter), .busy(busy), .done(done), .s_data_valid(s_data_valid),
    .s_data_ready(s_data_ready), .s_data(s_data), .dp_filter(dp_filter), .dp_data(dp_data),
    .dp_y(dp_y), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready), .m_y(m_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Direct 3x3 valid correlation: the result any correct Winograd F(2x2,3x3) chain must give.
  function automatic logic [127:0] golden(input logic [71:0] f, input logic [127:0] d);
    logic [127:0] y;
    int acc;
    y = '0;
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        acc = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            acc += int'(f[(r*3+c)*8 +: 8]) * int'(d[((oy+r)*4+ox+c)*8 +: 8]);
        y[(oy*2+ox)*32 +: 32] = acc;
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] mk_tile(input int i);
    logic [127:0] t;
    for (int b = 0; b < 16; b++) t[b*8 +: 8] = 8'((i*5 + b*3 + 1) & 127);
    return t;
  endfunction

  // Datapath model: three registered stages from dp_data to dp_y.
  always @(posedge clk) begin
    m1   <= golden(dp_filter, dp_data);
    m2   <= m1;
    dp_y <= m2;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard push on accept, pop/compare on result handshake, protocol checks.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (s_data_valid && s_data_ready) begin
        sb_q.push_back(golden(exp_filter, s_data));
        acc_cyc.push_back(cyc);
      end
      if (prev_valid && !prev_ready) begin
        check("m_y_stable", m_y, prev_y);
        check("m_y_valid_held", 128'(m_y_valid), 128'd1);
      end
      if (m_y_valid && !prev_valid) vrise_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("no_spurious_valid", 128'(m_y_valid), 128'd0);
      end else if (m_y_valid && m_y_ready) begin
        exp_y = sb_q.pop_front();
        check("m_y", m_y, exp_y);
        pop_cyc.push_back(cyc);
        last_y = m_y;
      end
      if (done) begin
        check("done_width", 128'(prev_done), 128'd0);
        done_cyc.push_back(cyc);
      end
      prev_valid = m_y_valid;
      prev_ready = m_y_ready;
      prev_done  = done;
      prev_y     = m_y;
    end
  end

  task automatic start_job(input logic [71:0] f, input logic [15:0] n);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_filter = f; cfg_num_tiles = n; exp_filter = f;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_tile(input logic [127:0] d);
    int w;
    w = 0;
    s_data = d;
    s_data_valid = 1'b1;
    @(negedge clk);
    while (!s_data_ready && !abort && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    if (!abort) check("src_wait_bound", 128'(w < LIMIT), 128'd1);
    @(posedge clk); #1;
    s_data_valid = 1'b0;
  endtask

  task automatic send_tiles(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      send_tile(mk_tile(base + i));
    end
    sender_busy = 1'b0;
  endtask

  task automatic wait_sender();
    int w;
    w = 0;
    while (sender_busy && w < LIMIT) begin
      @(negedge clk); #1;
      w++;
    end
    check("sender_bound", 128'(sender_busy), 128'd0);
  endtask

  task automatic snap();
    a0 = acc_cyc.size(); p0 = pop_cyc.size(); v0 = vrise_cyc.size(); d0 = done_cyc.size();
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done_cyc.size() == d0 && w < LIMIT) begin
      @(negedge clk); #1;
      w++;
    end
    check("done_seen", 128'(done_cyc.size() > d0), 128'd1);
    check("busy_low_at_done", 128'(busy), 128'd0);
    @(negedge clk); #1;
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, 128'(busy), 128'd0);
    check({p, "_done"}, 128'(done), 128'd0);
    check({p, "_s_data_ready"}, 128'(s_data_ready), 128'd0);
    check({p, "_m_y_valid"}, 128'(m_y_valid), 128'd0);
    check({p, "_m_y"}, m_y, 128'd0);
    check({p, "_dp_filter"}, 128'(dp_filter), 128'd0);
    check({p, "_dp_data"}, dp_data, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_num_tiles = '0; cfg_filter = '0;
    s_data_valid = 1'b0; s_data = '0; m_y_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // T1: single tile, exact latency, hand-computed result, done after pop.
    m_y_ready = 1'b1;
    snap();
    start_job(F1, 16'd1);
    @(negedge clk);
    check("t1_busy", 128'(busy), 128'd1);
    check("t1_dp_filter", 128'(dp_filter), 128'(F1));
    check("t1_fload_not_ready", 128'(s_data_ready), 128'd0);
    send_tile(D1);
    check("t1_dp_data", dp_data, D1);
    wait_done();
    check("t1_accepts", 128'(acc_cyc.size() - a0), 128'd1);
    check("t1_pops", 128'(pop_cyc.size() - p0), 128'd1);
    check("t1_latency", 128'(vrise_cyc[v0] - acc_cyc[a0]), 128'd5);
    check("t1_result", last_y, Y1);
    check("t1_done_after_pop", 128'(done_cyc[d0] - pop_cyc[p0]), 128'd2);
    check("t1_done_count", 128'(done_cyc.size() - d0), 128'd1);

    // T2: streaming at one tile per cycle.
    snap();
    start_job(F2, 16'd8);
    sender_busy = 1'b1;
    send_tiles(10, 8);
    wait_done();
    check("t2_accepts", 128'(acc_cyc.size() - a0), 128'd8);
    check("t2_accept_span", 128'(acc_cyc[a0+7] - acc_cyc[a0]), 128'd7);
    check("t2_pops", 128'(pop_cyc.size() - p0), 128'd8);
    check("t2_pop_span", 128'(pop_cyc[p0+7] - pop_cyc[p0]), 128'd7);
    check("t2_done_count", 128'(done_cyc.size() - d0), 128'd1);

    // T3: backpressure fills the credit pool, then drains in order.
    m_y_ready = 1'b0;
    snap();
    start_job(F1, 16'd16);
    sender_busy = 1'b1;
    fork
      send_tiles(30, 16);
    join_none
    repeat (40) @(negedge clk);
    #1;
    check("t3_accepts_stalled", 128'(acc_cyc.size() - a0), 128'd8);
    check("t3_ready_low", 128'(s_data_ready), 128'd0);
    check("t3_valid_full", 128'(m_y_valid), 128'd1);
    check("t3_no_pops", 128'(pop_cyc.size() - p0), 128'd0);
    @(posedge clk); #1;
    m_y_ready = 1'b1;
    wait_sender();
    wait_done();
    check("t3_accepts", 128'(acc_cyc.size() - a0), 128'd16);
    check("t3_pops", 128'(pop_cyc.size() - p0), 128'd16);
    check("t3_done_count", 128'(done_cyc.size() - d0), 128'd1);

    // T4: zero-tile job completes immediately without going busy.
    snap();
    start_job(F2, 16'd0);
    @(negedge clk);
    check("t4_done", 128'(done), 128'd1);
    check("t4_busy", 128'(busy), 128'd0);
    check("t4_ready", 128'(s_data_ready), 128'd0);
    check("t4_valid", 128'(m_y_valid), 128'd0);
    @(negedge clk);
    check("t4_done_drop", 128'(done), 128'd0);
    check("t4_busy_after", 128'(busy), 128'd0);
    #1;
    check("t4_done_count", 128'(done_cyc.size() - d0), 128'd1);

    // T5: cfg_start during RUN is ignored.
    snap();
    start_job(F3, 16'd4);
    sender_busy = 1'b1;
    fork
      send_tiles(50, 4);
    join_none
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_filter = F1; cfg_num_tiles = 16'd2;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check("t5_dp_filter_kept", 128'(dp_filter), 128'(F3));
    check("t5_busy", 128'(busy), 128'd1);
    wait_sender();
    wait_done();
    check("t5_accepts", 128'(acc_cyc.size() - a0), 128'd4);
    check("t5_pops", 128'(pop_cyc.size() - p0), 128'd4);
    check("t5_done_count", 128'(done_cyc.size() - d0), 128'd1);

    // T6: asynchronous reset with three tiles in flight, then a fresh job.
    snap();
    start_job(F1, 16'd8);
    sender_busy = 1'b1;
    fork
      send_tiles(70, 8);
    join_none
    begin
      int w;
      w = 0;
      while (acc_cyc.size() < a0 + 3 && w < LIMIT) begin
        @(negedge clk); #1;
        w++;
      end
      check("t6_three_accepts", 128'(acc_cyc.size() - a0), 128'd3);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    abort = 1'b1;
    #1;
    check_zero("t6_async");
    sb_q.delete();
    s_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_sender();
    p0 = pop_cyc.size();
    repeat (12) @(negedge clk);
    #1;
    check("t6_no_results", 128'(pop_cyc.size() - p0), 128'd0);
    check("t6_valid_low", 128'(m_y_valid), 128'd0);
    abort = 1'b0;
    snap();
    start_job(F2, 16'd3);
    sender_busy = 1'b1;
    send_tiles(90, 3);
    wait_done();
    check("t6_new_pops", 128'(pop_cyc.size() - p0), 128'd3);
    check("t6_new_done_count", 128'(done_cyc.size() - d0), 128'd1);
    check("t6_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
